// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receive FSM state encoding
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} rx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 1250;
endpackage

// File: rtl/uart_rx_frontend_if.sv
// uart_rx_frontend_if: valid/ready byte stream out of the receive front end
interface uart_rx_frontend_if;
  import uart_pkg::*;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  modport master(output rx_data, output rx_valid, input rx_ready);
  modport slave(input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: first-word-fall-through FIFO; a push while full is taken only alongside a pop
module uart_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  always_comb begin
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    wr = push && (!full || pop);
    rd = pop && !empty;
    dout = empty ? '0 : mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: synchronises uartrx, deserialises 8N1 frames and buffers bytes in a FIFO
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic hw_clk,
  input  logic reset,
  input  logic uartrx,
  uart_rx_frontend_if.master rx,
  output logic rx_busy,
  output logic framing_err,
  output logic overrun_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  rx_state_t state, state_n;
  logic [1:0] sync;
  logic rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic push, ferr, full, empty, pop, tick, half;
  assign rx_s = sync[1];
  assign tick = cnt == CW'(CLKS_PER_BIT);
  assign half = cnt == CW'(CLKS_PER_BIT / 2);
  assign pop = rx.rx_valid && rx.rx_ready;
  assign rx.rx_valid = !empty;
  assign rx_busy = state != IDLE;
  // cnt reads 1 in the first cycle after a transition, so a compare with N marks N cycles elapsed
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bit_n = bit_idx;
    shift_n = shift;
    push = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = CW'(1);
        if (!rx_s) begin
          state_n = START;
          bit_n = '0;
        end
      end
      START: if (half) begin
        cnt_n = CW'(1);
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_n = CW'(1);
        shift_n = {rx_s, shift[UART_DATA_BITS-1:1]};
        bit_n = bit_idx + 3'd1;
        state_n = bit_idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        state_n = rx_s ? IDLE : BREAK_WAIT;
        push = rx_s;
        ferr = !rx_s;
      end
      BREAK_WAIT: state_n = rx_s ? IDLE : BREAK_WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge hw_clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync <= {sync[0], uartrx};
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      shift <= shift_n;
      framing_err <= ferr;
      overrun_err <= push && full && !pop;
    end
  end
  uart_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
    .clk(hw_clk),
    .rst(reset),
    .push(push),
    .pop(pop),
    .din(shift_n),
    .dout(rx.rx_data),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed frame scenarios with hand-computed expectations
module tb_uart_rx_frontend;
  logic hw_clk = 1'b0;
  logic reset = 1'b1;
  logic uartrx = 1'b1;
  logic rx_busy, framing_err, overrun_err;
  int vectors = 0;
  int miscompares = 0;
  int ferr_cnt = 0;
  int oerr_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] got [$];
  uart_rx_frontend_if rx();
  uart_rx_frontend #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .hw_clk(hw_clk),
    .reset(reset),
    .uartrx(uartrx),
    .rx(rx),
    .rx_busy(rx_busy),
    .framing_err(framing_err),
    .overrun_err(overrun_err)
  );
  always #5 hw_clk = ~hw_clk;
  always @(negedge hw_clk) begin
    if (rx.rx_valid && rx.rx_ready) got.push_back(rx.rx_data);
    if (framing_err) ferr_cnt++;
    if (overrun_err) oerr_cnt++;
    if (rx_busy) busy_cnt++;
  end
  task clear_mon();
    @(posedge hw_clk);
    got.delete();
    ferr_cnt = 0;
    oerr_cnt = 0;
    busy_cnt = 0;
  endtask
  task set_ready(input logic r);
    @(posedge hw_clk);
    #1 rx.rx_ready = r;
  endtask
  task send_frame(input logic [7:0] b, input logic stopb, input int pk);
    logic [9:0] fb;
    fb = {stopb, b, 1'b0};
    for (int k = 0; k < 160; k++) begin
      @(negedge hw_clk);
      uartrx = fb[k/16];
      if (k == pk) begin @(posedge hw_clk); #1 rx.rx_ready = 1'b1; end
      if (k == pk + 1) begin @(posedge hw_clk); #1 rx.rx_ready = 1'b0; end
    end
  endtask
  task test_reset();
    rx.rx_ready = 1'b0;
    repeat (3) @(posedge hw_clk);
    #2;
    vectors++;
    if ({rx.rx_valid, rx.rx_data, rx_busy, framing_err, overrun_err} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 000", {rx.rx_valid, rx.rx_data, rx_busy, framing_err, overrun_err});
    end
    #1 reset = 1'b0;
    repeat (4) @(negedge hw_clk);
    vectors++;
    if ({rx.rx_valid, rx_busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b want 00", {rx.rx_valid, rx_busy});
    end
  endtask
  task test_single_frame();
    logic [9:0] fb;
    int first, vcnt;
    logic [7:0] fdata;
    logic b2, b3, b154, b155;
    fb = {1'b1, 8'hA5, 1'b0};
    first = -1;
    vcnt = 0;
    fdata = '0;
    {b2, b3, b154, b155} = '0;
    set_ready(1'b1);
    clear_mon();
    for (int k = 0; k < 200; k++) begin
      @(negedge hw_clk);
      if (rx.rx_valid) begin
        vcnt++;
        if (first < 0) begin first = k; fdata = rx.rx_data; end
      end
      if (k == 2) b2 = rx_busy;
      if (k == 3) b3 = rx_busy;
      if (k == 154) b154 = rx_busy;
      if (k == 155) b155 = rx_busy;
      uartrx = k < 160 ? fb[k/16] : 1'b1;
    end
    vectors++;
    if (first !== 155) begin miscompares++; $display("FAIL single_valid_time: got %0d want 155", first); end
    vectors++;
    if (vcnt !== 1) begin miscompares++; $display("FAIL single_valid_len: got %0d want 1", vcnt); end
    vectors++;
    if (fdata !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h want a5", fdata); end
    vectors++;
    if ({b2, b3, b154, b155} !== 4'b0110) begin
      miscompares++;
      $display("FAIL single_busy_window: got %b want 0110", {b2, b3, b154, b155});
    end
    vectors++;
    if (ferr_cnt + oerr_cnt !== 0) begin miscompares++; $display("FAIL single_errors: got %0d want 0", ferr_cnt + oerr_cnt); end
  endtask
  task test_glitch();
    clear_mon();
    for (int k = 0; k < 60; k++) begin
      @(negedge hw_clk);
      uartrx = k < 4 ? 1'b0 : 1'b1;
    end
    vectors++;
    if (busy_cnt !== 8) begin miscompares++; $display("FAIL glitch_busy_cycles: got %0d want 8", busy_cnt); end
    vectors++;
    if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL glitch_back_idle: got %b want 0", rx_busy); end
    vectors++;
    if (got.size() + ferr_cnt !== 0) begin
      miscompares++;
      $display("FAIL glitch_no_output: got %0d bytes %0d ferr want 0 0", got.size(), ferr_cnt);
    end
  endtask
  task test_framing();
    clear_mon();
    send_frame(8'h3C, 1'b0, -10);
    for (int k = 0; k < 640; k++) @(negedge hw_clk);
    vectors++;
    if (rx_busy !== 1'b1) begin miscompares++; $display("FAIL break_wait_busy: got %b want 1", rx_busy); end
    uartrx = 1'b1;
    repeat (20) @(negedge hw_clk);
    send_frame(8'h11, 1'b1, -10);
    repeat (20) @(negedge hw_clk);
    vectors++;
    if (ferr_cnt !== 1) begin miscompares++; $display("FAIL framing_pulses: got %0d want 1", ferr_cnt); end
    vectors++;
    if (got.size() !== 1) begin
      miscompares++;
      $display("FAIL framing_bytes: got %0d want 1", got.size());
    end else begin
      vectors++;
      if (got[0] !== 8'h11) begin miscompares++; $display("FAIL framing_next_byte: got %h want 11", got[0]); end
    end
  endtask
  task test_back_to_back_overrun();
    logic [7:0] exp [4];
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    set_ready(1'b0);
    clear_mon();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -10);
    repeat (5) @(negedge hw_clk);
    vectors++;
    if (oerr_cnt !== 1) begin miscompares++; $display("FAIL overrun_pulses: got %0d want 1", oerr_cnt); end
    vectors++;
    if ({rx.rx_valid, rx.rx_data} !== 9'h101) begin
      miscompares++;
      $display("FAIL overrun_head: got %h want 101", {rx.rx_valid, rx.rx_data});
    end
    set_ready(1'b1);
    repeat (8) @(posedge hw_clk);
    #1 rx.rx_ready = 1'b0;
    vectors++;
    if (got.size() !== 4) begin
      miscompares++;
      $display("FAIL overrun_drain_count: got %0d want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (got[i] !== exp[i]) begin miscompares++; $display("FAIL overrun_drain_%0d: got %h want %h", i, got[i], exp[i]); end
      end
    end
  endtask
  task test_full_pop_same_cycle();
    logic [7:0] exp [4];
    exp = '{8'h02, 8'h03, 8'h04, 8'h05};
    set_ready(1'b0);
    clear_mon();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -10);
    send_frame(8'h05, 1'b1, 153);
    repeat (5) @(negedge hw_clk);
    vectors++;
    if (oerr_cnt !== 0) begin miscompares++; $display("FAIL full_pop_overrun: got %0d want 0", oerr_cnt); end
    vectors++;
    if (got.size() !== 1 || got[0] !== 8'h01) begin
      miscompares++;
      $display("FAIL full_pop_popped: got %0d bytes want one 01", got.size());
    end
    clear_mon();
    set_ready(1'b1);
    repeat (8) @(posedge hw_clk);
    #1 rx.rx_ready = 1'b0;
    vectors++;
    if (got.size() !== 4) begin
      miscompares++;
      $display("FAIL full_pop_drain_count: got %0d want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (got[i] !== exp[i]) begin miscompares++; $display("FAIL full_pop_drain_%0d: got %h want %h", i, got[i], exp[i]); end
      end
    end
  endtask
  task test_reset_mid_frame();
    logic [9:0] fb;
    fb = {1'b1, 8'hFF, 1'b0};
    set_ready(1'b0);
    send_frame(8'h10, 1'b1, -10);
    send_frame(8'h20, 1'b1, -10);
    for (int k = 0; k < 60; k++) begin
      @(negedge hw_clk);
      uartrx = fb[k/16];
    end
    vectors++;
    if ({rx.rx_valid, rx.rx_data, rx_busy} !== 10'h221) begin
      miscompares++;
      $display("FAIL pre_reset_state: got %h want 221", {rx.rx_valid, rx.rx_data, rx_busy});
    end
    @(posedge hw_clk);
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({rx.rx_valid, rx.rx_data, rx_busy, framing_err, overrun_err} !== 12'h000) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %h want 000", {rx.rx_valid, rx.rx_data, rx_busy, framing_err, overrun_err});
    end
    uartrx = 1'b1;
    repeat (2) @(posedge hw_clk);
    #1 reset = 1'b0;
    clear_mon();
    set_ready(1'b1);
    repeat (10) @(negedge hw_clk);
    send_frame(8'h42, 1'b1, -10);
    repeat (20) @(negedge hw_clk);
    vectors++;
    if (got.size() !== 1 || got[0] !== 8'h42) begin
      miscompares++;
      $display("FAIL reset_next_frame: got %0d bytes want one 42", got.size());
    end
    vectors++;
    if (ferr_cnt + oerr_cnt !== 0) begin miscompares++; $display("FAIL reset_errors: got %0d want 0", ferr_cnt + oerr_cnt); end
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_framing();
    test_back_to_back_overrun();
    test_full_pop_same_cycle();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial receive front end that sits directly upstream of the `rgb_blink` application logic and turns the raw `uartrx` pin into a buffered byte stream. It synchronises the asynchronous line, detects and validates start bits, and deserialises 8N1 frames using a fixed clocks-per-bit divider. Received bytes go into a small first-word-fall-through FIFO behind a valid/ready handshake. Framing and overrun errors are flagged as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 1250: `hw_clk` cycles per UART bit (12 MHz / 9600 baud); must be ≥ 8.
- `FIFO_DEPTH`, 4: byte buffer entries; must be a power of two, ≥ 2.
- `hw_clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `uartrx` input 1: raw serial line, idle high, asynchronous to `hw_clk`.
- `rx_data` output 8: head FIFO byte, LSB first on the wire; valid only while `rx_valid`.
- `rx_valid` output 1: FIFO not empty.
- `rx_ready` input 1: consumer accepts head byte when `rx_valid && rx_ready`.
- `rx_busy` output 1: high in any non-IDLE receive state.
- `framing_err` output 1: one-cycle pulse, stop bit sampled low.
- `overrun_err` output 1: one-cycle pulse, good byte dropped because FIFO full.

## Operation
- Reset: all outputs 0; FSM in IDLE; FIFO empty; synchroniser flops preset to 1 (line idle).
- `uartrx` passes through a 2-flop synchroniser giving `rx_s`; all decisions use `rx_s` only.
- FSM states: IDLE, START, DATA, STOP, BREAK_WAIT.
- IDLE: on `rx_s == 0` go to START and clear the bit counter.
- START: at count `CLKS_PER_BIT/2` (integer division), if `rx_s == 0` go to DATA; else treat it as a glitch and return to IDLE with no error.
- DATA: sample `rx_s` every `CLKS_PER_BIT` cycles into a shift register, LSB first; after bit 7 go to STOP.
- STOP: sample after `CLKS_PER_BIT` cycles.
  - `rx_s == 1`: push the byte and return to IDLE.
  - `rx_s == 0`: pulse `framing_err`, discard the byte, go to BREAK_WAIT.
- BREAK_WAIT: stay until `rx_s == 1`, then go to IDLE. A held-low line yields exactly one `framing_err`.
- FIFO push when full:
  - If a pop happens in the same cycle, the push is accepted.
  - Otherwise the new byte is dropped, `overrun_err` pulses, and FIFO contents are unchanged.
- Pop on an empty FIFO is impossible by construction (`rx_valid` is 0).
- Pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap modulo 2·DEPTH; full and empty are decided by the MSB compare.

## Timing
- t0 is the first cycle `rx_s` is low; the pin edge precedes t0 by 2 cycles.
- Start check at t0 + `CLKS_PER_BIT/2`.
- Data bit i (0..7) sampled at t0 + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`.
- Stop sample at t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- Push is registered on the stop-sample edge. `rx_valid` and `rx_data` update the next cycle when the FIFO was empty, since the FIFO is first-word-fall-through.
- `framing_err` and `overrun_err` are high in the cycle after the stop sample, for exactly one cycle.
- The next start bit can be detected the cycle after returning to IDLE; back-to-back frames with one stop bit are supported.
- `reset` asserted mid-frame: the partial byte is lost, FIFO contents are lost, and no error pulse is emitted.

## Structure
- Shared package `uart_pkg`: FSM state enum, `UART_DATA_BITS = 8`, and a default `CLKS_PER_BIT` constant reused by the future TX block.
- One sub-module, `uart_byte_fifo` (DEPTH, WIDTH): synchronous FWFT FIFO with push, pop, full, empty, and async active-high reset.
- The synchroniser, counter, and FSM stay in `uart_rx_frontend`.

## Test plan
All scenarios use `CLKS_PER_BIT = 16` and `FIFO_DEPTH = 4`.
- Single frame 0xA5, `rx_ready = 1`:
  - `rx_valid` is high for 1 cycle at t0+153 with `rx_data = 0xA5`.
  - No errors; `rx_busy` is low from t0+153.
- Glitch: low pulse of 4 cycles on `uartrx`:
  - `rx_busy` pulses, then returns to IDLE.
  - No `rx_valid`, no `framing_err`.
- Stop bit forced low on byte 0x3C, then line held low 40 bit-times:
  - Exactly one `framing_err` pulse.
  - No push.
  - The next valid frame 0x11 is received correctly.
- Overrun: 5 back-to-back frames 0x01..0x05 with `rx_ready = 0`:
  - FIFO holds 0x01..0x04.
  - One `overrun_err` on the 5th frame.
  - Draining yields 0x01, 0x02, 0x03, 0x04 in order.
- Full FIFO with `rx_ready` asserted in the stop-sample cycle of the 5th frame:
  - No `overrun_err`.
  - 0x05 is retained.
- `reset` asserted mid-DATA of 0xFF with 2 bytes buffered:
  - All outputs return to 0 immediately.
  - The following frame 0x42 is received alone.
